// File: rtl/sfilt_pkg.sv
// Shared types for the serial filter: MAC command codes, sequencer states and the MAC command payload.
package sfilt_pkg;

    localparam int unsigned DW  = 32;
    localparam int unsigned SHW = 7;

    localparam logic [1:0] CMD_FIRST = 2'd0;
    localparam logic [1:0] CMD_MAC   = 2'd1;
    localparam logic [1:0] CMD_SHIFT = 2'd2;
    localparam logic [1:0] CMD_OUT   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TAP   = 2'd1,
        SHIFT = 2'd2,
        FLUSH = 2'd3
    } state_e;

    typedef struct packed {
        logic          pushin;
        logic [1:0]    cmd;
        logic [DW-1:0] q;
        logic [DW-1:0] h;
    } mac_cmd_t;

endpackage

// File: rtl/fir_delay_line.sv
// Circular NTAPS x DW sample store: one write port, one combinational read port, synchronous clear.
module fir_delay_line
    import sfilt_pkg::*;
#(
    parameter  int unsigned NTAPS = 8,
    localparam int unsigned AW    = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata_c
);

    logic [DW-1:0] r_line [NTAPS];

    // Clear happens before the write so a sample can land in a freshly cleared line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NTAPS); i++) r_line[i] <= '0;
        end else begin
            if (i_clr) begin
                for (int i = 0; i < int'(NTAPS); i++) r_line[i] <= '0;
            end
            if (i_we) r_line[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_line[i_raddr];

endmodule

// File: rtl/fir_cmd_seq.sv
// Per-sample command sequencer for the serial MAC: stores samples/coefficients and
// streams FIRST, NTAPS-1 MACs, SHIFT and OUT commands without ever stalling.
module fir_cmd_seq
    import sfilt_pkg::*;
#(
    parameter  int unsigned NTAPS = 8,
    localparam int unsigned AW    = $clog2(NTAPS)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           din_valid,
    output logic           din_ready,
    input  logic [DW-1:0]  din,
    input  logic           coef_we,
    input  logic [AW-1:0]  coef_addr,
    input  logic [DW-1:0]  coef_wdata,
    input  logic [SHW-1:0] shift,
    input  logic           hist_clr,
    output logic           busy,
    output logic           pushin,
    output logic [1:0]     cmd,
    output logic [DW-1:0]  q,
    output logic [DW-1:0]  h
);

    state_e          r_state, w_state_nxt;
    logic [AW-1:0]   r_k, w_k_nxt;
    logic [AW-1:0]   r_wptr, w_wptr_nxt;
    logic [SHW-1:0]  r_shift, w_shift_nxt;
    mac_cmd_t        r_mac, w_mac_nxt;
    logic            r_din_ready, r_busy;
    logic [DW-1:0]   r_coef [NTAPS];

    logic            w_idle, w_clr, w_accept;
    logic [AW-1:0]   w_waddr, w_raddr;
    logic [DW-1:0]   w_rdata;

    assign w_idle   = (r_state == IDLE);
    assign w_clr    = w_idle && hist_clr;
    assign w_accept = w_idle && din_valid;
    assign w_waddr  = w_clr ? '0 : r_wptr;
    assign w_raddr  = r_wptr - r_k;

    fir_delay_line #(.NTAPS(NTAPS)) u_line (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_clr),
        .i_we      (w_accept),
        .i_waddr   (w_waddr),
        .i_wdata   (din),
        .i_raddr   (w_raddr),
        .o_rdata_c (w_rdata)
    );

    // Coefficient bank: writable in any state; a read in the write cycle sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NTAPS); i++) r_coef[i] <= '0;
        end else if (coef_we) begin
            r_coef[coef_addr] <= coef_wdata;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_k_nxt        = r_k;
        w_wptr_nxt     = r_wptr;
        w_shift_nxt    = r_shift;
        w_mac_nxt      = r_mac;
        w_mac_nxt.pushin = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_clr) w_wptr_nxt = '0;
                if (din_valid) begin
                    w_shift_nxt = shift;
                    w_k_nxt     = '0;
                    w_state_nxt = TAP;
                end
            end
            TAP: begin
                w_mac_nxt = '{pushin: 1'b1,
                              cmd:    (r_k == '0) ? CMD_FIRST : CMD_MAC,
                              q:      w_rdata,
                              h:      r_coef[r_k]};
                w_k_nxt = r_k + AW'(1);
                if (r_k == AW'(NTAPS - 1)) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                w_mac_nxt   = '{pushin: 1'b1, cmd: CMD_SHIFT, q: '0, h: DW'(r_shift)};
                w_state_nxt = FLUSH;
            end
            FLUSH: begin
                w_mac_nxt   = '{pushin: 1'b1, cmd: CMD_OUT, q: '0, h: '0};
                w_wptr_nxt  = r_wptr + AW'(1);
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_wptr      <= '0;
            r_shift     <= '0;
            r_mac       <= '0;
            r_din_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_wptr      <= w_wptr_nxt;
            r_shift     <= w_shift_nxt;
            r_mac       <= w_mac_nxt;
            r_din_ready <= (w_state_nxt == IDLE);
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    assign din_ready = r_din_ready;
    assign busy      = r_busy;
    assign pushin    = r_mac.pushin;
    assign cmd       = r_mac.cmd;
    assign q         = r_mac.q;
    assign h         = r_mac.h;

endmodule

// File: tb/tb_fir_cmd_seq.sv
// Directed bench for fir_cmd_seq with NTAPS=4: command streams, history order, wrap, handshake, clears, reset.
module tb_fir_cmd_seq;

    localparam int unsigned NTAPS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [31:0] din = '0;
    logic        coef_we = 1'b0;
    logic [1:0]  coef_addr = '0;
    logic [31:0] coef_wdata = '0;
    logic [6:0]  shift = '0;
    logic        hist_clr = 1'b0;
    logic        busy;
    logic        pushin;
    logic [1:0]  cmd;
    logic [31:0] q;
    logic [31:0] h;

    int n_cmp = 0;
    int n_mis = 0;

    fir_cmd_seq #(.NTAPS(NTAPS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din        (din),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .shift      (shift),
        .hist_clr   (hist_clr),
        .busy       (busy),
        .pushin     (pushin),
        .cmd        (cmd),
        .q          (q),
        .h          (h)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0][31:0] v4(input logic [31:0] a, b, c, d);
        logic [3:0][31:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    task automatic wcoef(input logic [1:0] k, input logic [31:0] v);
        coef_we = 1'b1; coef_addr = k; coef_wdata = v;
        tick();
        coef_we = 1'b0;
    endtask

    task automatic pulse_clr();
        hist_clr = 1'b1;
        tick();
        hist_clr = 1'b0;
    endtask

    // Accept one sample and check the full NTAPS+2 command stream that follows it.
    task automatic send_check(input string tag, input logic [31:0] d, input logic [6:0] sh,
                              input logic clr, input logic [3:0][31:0] eq, input logic [3:0][31:0] eh,
                              input int cw_at, input logic [1:0] cw_addr, input logic [31:0] cw_data);
        int n;
        logic [1:0]  ec;
        logic [31:0] eqv, ehv;
        n = 0;
        while (din_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, " ready before accept"}, 64'(din_ready), 64'(1));
        din_valid = 1'b1; din = d; shift = sh; hist_clr = clr;
        tick();
        din_valid = 1'b0; din = '0; shift = '0; hist_clr = 1'b0;
        check({tag, " busy/ready after accept"}, 64'({busy, din_ready}), 64'(2'b10));
        for (int i = 0; i < int'(NTAPS) + 2; i++) begin
            if (i == cw_at) begin
                coef_we = 1'b1; coef_addr = cw_addr; coef_wdata = cw_data;
            end
            tick();
            coef_we = 1'b0;
            ec  = (i == 0) ? 2'd0 : (i < int'(NTAPS)) ? 2'd1 : (i == int'(NTAPS)) ? 2'd2 : 2'd3;
            eqv = (i < int'(NTAPS)) ? eq[i] : 32'd0;
            ehv = (i < int'(NTAPS)) ? eh[i] : (i == int'(NTAPS)) ? 32'(sh) : 32'd0;
            check($sformatf("%s pushin/cmd[%0d]", tag, i), 64'({pushin, cmd}), 64'({1'b1, ec}));
            check($sformatf("%s q/h[%0d]", tag, i), {q, h}, {eqv, ehv});
        end
        check({tag, " ready/busy after flush"}, 64'({din_ready, busy}), 64'(2'b10));
        tick();
        check({tag, " idle hold"}, {29'd0, pushin, cmd, q}, {29'd0, 1'b0, 2'd3, 32'd0});
    endtask

    initial begin
        // Reset and idle
        tick(); tick();
        check("reset pushin/cmd", 64'({pushin, cmd}), 64'(0));
        check("reset q/h", {q, h}, 64'(0));
        check("reset ready/busy", 64'({din_ready, busy}), 64'(2'b10));
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle pushin", 64'(pushin), 64'(0));
        end
        check("idle ready", 64'(din_ready), 64'(1));

        // First sample and history order
        wcoef(2'd0, 32'd1); wcoef(2'd1, 32'd2); wcoef(2'd2, 32'd3); wcoef(2'd3, 32'd4);
        send_check("s10", 32'd10, 7'd5, 1'b0, v4(10, 0, 0, 0), v4(1, 2, 3, 4), -1, 2'd0, 32'd0);
        send_check("s20", 32'd20, 7'd5, 1'b0, v4(20, 10, 0, 0), v4(1, 2, 3, 4), -1, 2'd0, 32'd0);
        send_check("s30", 32'd30, 7'd5, 1'b0, v4(30, 20, 10, 0), v4(1, 2, 3, 4), -1, 2'd0, 32'd0);

        // Wrap-around from a cleared history
        pulse_clr();
        send_check("w1", 32'd1, 7'd2, 1'b0, v4(1, 0, 0, 0), v4(1, 2, 3, 4), -1, 2'd0, 32'd0);
        send_check("w2", 32'd2, 7'd2, 1'b0, v4(2, 1, 0, 0), v4(1, 2, 3, 4), -1, 2'd0, 32'd0);
        send_check("w3", 32'd3, 7'd2, 1'b0, v4(3, 2, 1, 0), v4(1, 2, 3, 4), -1, 2'd0, 32'd0);
        send_check("w4", 32'd4, 7'd2, 1'b0, v4(4, 3, 2, 1), v4(1, 2, 3, 4), -1, 2'd0, 32'd0);
        send_check("w5", 32'd5, 7'd127, 1'b0, v4(5, 4, 3, 2), v4(1, 2, 3, 4), -1, 2'd0, 32'd0);

        // Continuous din_valid: one accept per 7 cycles; hist_clr while busy is ignored
        din = 32'd100; din_valid = 1'b1;
        for (int j = 0; j < 21; j++) begin
            hist_clr = (j == 2);
            tick();
            check($sformatf("stream ready j=%0d", j), 64'(din_ready), 64'((j % 7) == 6));
            if (j == 20) din_valid = 1'b0;
        end
        hist_clr = 1'b0; din = '0;
        send_check("s9", 32'd9, 7'd1, 1'b0, v4(9, 100, 100, 100), v4(1, 2, 3, 4), -1, 2'd0, 32'd0);

        // hist_clr in IDLE, and together with din_valid
        pulse_clr();
        send_check("s11", 32'd11, 7'd1, 1'b0, v4(11, 0, 0, 0), v4(1, 2, 3, 4), -1, 2'd0, 32'd0);
        send_check("s12", 32'd12, 7'd1, 1'b1, v4(12, 0, 0, 0), v4(1, 2, 3, 4), -1, 2'd0, 32'd0);

        // Coefficient write in the cycle it is read gives the old value, new value next sample
        send_check("s13", 32'd13, 7'd0, 1'b0, v4(13, 12, 0, 0), v4(1, 2, 3, 4), 1, 2'd1, 32'd50);
        send_check("s14", 32'd14, 7'd0, 1'b0, v4(14, 13, 12, 0), v4(1, 50, 3, 4), -1, 2'd0, 32'd0);

        // Mid-sequence reset
        din_valid = 1'b1; din = 32'd99;
        tick();
        din_valid = 1'b0; din = '0;
        tick();
        check("pre-reset pushin/cmd", 64'({pushin, cmd}), 64'(3'b100));
        rst_n = 1'b0;
        #1;
        check("async reset pushin/cmd", 64'({pushin, cmd}), 64'(0));
        check("async reset q/h", {q, h}, 64'(0));
        check("async reset ready/busy", 64'({din_ready, busy}), 64'(2'b10));
        tick();
        rst_n = 1'b1;
        tick();
        send_check("s7", 32'd7, 7'd3, 1'b0, v4(7, 0, 0, 0), v4(0, 0, 0, 0), -1, 2'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
